zprize_signed_digit_recoder: RTL

//  Splits each MSM scalar into NWIN signed C-bit window digits for bucket accumulation.

---
 rtl/zprize_signed_digit_recoder_if.sv | 34 +++
 rtl/zprize_signed_digit_recoder.sv | 115 +++++++++++
 2 files changed

// File: rtl/zprize_signed_digit_recoder_if.sv
// Scalar-in / signed-digit-out stream bundle for the MSM window recoder.
// The recoder takes the slave view; the feeder and scheduler take the master view.
interface zprize_signed_digit_recoder_if #(
    parameter int SCALAR_W = 253,
    parameter int C        = 16,
    parameter int NWIN     = 16,
    parameter int TAG_W    = 32
);
    localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;

    logic                s_valid;
    logic                s_ready;
    logic [SCALAR_W-1:0] s_scalar;
    logic [TAG_W-1:0]    s_tag;

    logic                m_valid;
    logic                m_ready;
    logic [WIN_W-1:0]    m_win;
    logic [C-1:0]        m_mag;
    logic                m_neg;
    logic                m_zero;
    logic [TAG_W-1:0]    m_tag;
    logic                m_last;

    modport slave (
        input  s_valid, s_scalar, s_tag, m_ready,
        output s_ready, m_valid, m_win, m_mag, m_neg, m_zero, m_tag, m_last
    );

    modport master (
        output s_valid, s_scalar, s_tag, m_ready,
        input  s_ready, m_valid, m_win, m_mag, m_neg, m_zero, m_tag, m_last
    );
endinterface

// File: rtl/zprize_signed_digit_recoder.sv
// Splits each MSM scalar into NWIN signed C-bit window digits (magnitude + neg flag),
// one digit per cycle, with no bubble between consecutive scalars.
//
// state | meaning
// IDLE  | no scalar loaded; s_ready=1, m_valid=0, shift/carry hold
// RUN   | emitting windows of the loaded scalar, win 0..NWIN-1
module zprize_signed_digit_recoder #(
    parameter int SCALAR_W = 253,
    parameter int C        = 16,
    parameter int NWIN     = 16,
    parameter int TAG_W    = 32
) (
    input  logic                         clk,
    input  logic                         rstN,
    zprize_signed_digit_recoder_if.slave bus,
    output logic                         err_carry,
    output logic                         idle
);
    localparam int WIN_W   = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int SHIFT_W = NWIN * C;
    localparam logic [C:0] HALF = {2'b01, {(C-1){1'b0}}};
    localparam logic [C:0] FULL = {1'b1, {C{1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_d;
    logic [SHIFT_W-1:0] shift;
    logic               carry;
    logic [WIN_W-1:0]   win;
    logic [TAG_W-1:0]   tag;

    logic [C:0]   d;
    logic [C:0]   d_neg;
    logic [C-1:0] mag;
    logic         neg;
    logic         carry_next;
    logic         run;
    logic         last;
    logic         fire;
    logic         accept;

    // d == 2^C folds to magnitude 0 with a carry out; neg is dropped so a zero digit
    // never requests a negated point.
    always_comb begin
        d          = {1'b0, shift[C-1:0]} + {{C{1'b0}}, carry};
        d_neg      = FULL - d;
        mag        = d[C-1:0];
        neg        = 1'b0;
        carry_next = 1'b0;
        if (d > HALF) begin
            mag        = d_neg[C-1:0];
            neg        = (d_neg != '0);
            carry_next = 1'b1;
        end
    end

    assign run    = (state == RUN);
    assign last   = run && (win == WIN_W'(NWIN - 1));
    assign fire   = run && bus.m_ready;
    assign accept = bus.s_valid && bus.s_ready;

    // Ready during the final beat lets the next scalar's window 0 follow immediately.
    assign bus.s_ready = !run || (fire && last);

    assign bus.m_valid = run;
    assign bus.m_win   = run ? win : '0;
    assign bus.m_mag   = run ? mag : '0;
    assign bus.m_neg   = run && neg;
    assign bus.m_zero  = run && (mag == '0);
    assign bus.m_tag   = run ? tag : '0;
    assign bus.m_last  = last;

    assign idle = (state == IDLE) && !bus.s_valid;

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (fire && last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shift     <= '0;
            carry     <= 1'b0;
            win       <= '0;
            tag       <= '0;
            err_carry <= 1'b0;
        end else begin
            if (accept) begin
                shift <= {{(SHIFT_W-SCALAR_W){1'b0}}, bus.s_scalar};
                tag   <= bus.s_tag;
                carry <= 1'b0;
                win   <= '0;
            end else if (fire) begin
                shift <= shift >> C;
                carry <= carry_next;
                win   <= win + WIN_W'(1);
            end
            if (fire && last && carry_next) err_carry <= 1'b1;
        end
    end

    // The top window must absorb every carry; NWIN*C >= SCALAR_W+1 guarantees it.
    assert property (@(posedge clk) disable iff (!rstN) !(fire && last && carry_next))
        else $error("carry left the top window");

endmodule
